// File: rtl/pwm_dac.sv
// PWM DAC: requests one code per 2**CODE_WIDTH-cycle window and plays it as a registered PWM duty.
// Define CENTER_ALIGN_EN for centre-aligned pulses; the default build is edge-aligned. dbg_state_o: 0=IDLE 1=PRIME 2=LOAD 3=RUN.
module pwm_dac #(
    parameter int CODE_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CODE_WIDTH-1:0] code,
    output logic                  next_sample,
    output logic                  pwm,
    output logic                  active,
    output logic [1:0]            dbg_state_o
);
    // Handshake: next_sample is high for one cycle; the source presents code on the following cycle,
    // where it is captured at that cycle's closing edge. code is ignored at all other times.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [CODE_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [CODE_WIDTH-1:0] CNT_REQ  = {{(CODE_WIDTH-1){1'b1}}, 1'b0};

    state_t                state_q, state_d;
    logic [CODE_WIDTH-1:0] cnt_q, cnt_d;
    logic [CODE_WIDTH-1:0] duty_q, duty_d;
    logic                  req_q, req_d;
    logic                  pwm_q, pwm_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
            req_q   <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            req_q   <= req_d;
            pwm_q   <= pwm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        req_d   = req_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                req_d = 1'b0;
                if (enable) state_d = S_PRIME;
            end
            S_PRIME: state_d = S_LOAD;
            S_LOAD: begin
                duty_d  = code;
                cnt_d   = '0;
                req_d   = 1'b0;
                state_d = S_RUN;
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_REQ) req_d = enable;
                // Window boundary: either take the requested code or retire to IDLE.
                if (cnt_q == CNT_LAST) begin
                    req_d = 1'b0;
                    if (req_q) duty_d = code;
                    else       state_d = S_IDLE;
                end
            end
        endcase
    end

`ifdef CENTER_ALIGN_EN
    logic [CODE_WIDTH:0] start_w;
    logic [CODE_WIDTH:0] stop_w;
    logic [CODE_WIDTH:0] cnt_w;
`endif

    always_comb begin
        next_sample = (state_q == S_PRIME) ||
                      ((state_q == S_RUN) && (cnt_q == CNT_REQ) && enable);
        active      = (state_q != S_IDLE);
        dbg_state_o = state_q;
`ifdef CENTER_ALIGN_EN
        // Extra bit keeps start+duty from wrapping when duty is near full scale.
        cnt_w   = {1'b0, cnt_q};
        start_w = ({1'b1, {CODE_WIDTH{1'b0}}} - {1'b0, duty_q}) >> 1;
        stop_w  = start_w + {1'b0, duty_q};
        pwm_d   = (state_q == S_RUN) && (cnt_w >= start_w) && (cnt_w < stop_w);
`else
        pwm_d   = (state_q == S_RUN) && (cnt_q < duty_q);
`endif
    end

    assign pwm = pwm_q;

endmodule
